qu_instr_decode: RTL and testbench
==================================

// Module: qu_instr_decode
// PURPOSE
//  Decode stage of the Qu pipeline: accepts 32-bit RV32I instruction words plus PC from fetch,
//  splits them into register addresses, funct fields, class and sign-extended 32-bit immediate.
//  Registered output, valid/ready on both sides, 2-entry skid buffer for full throughput with a
//  registered ready_o. Exact inverse of the qu_common get_encoding_* encoders.
// PARAMETERS
//  QU_INSTR_WIDTH  32  instruction word width (qu_common); only 32 supported
//  QU_PC_WIDTH     12  PC width (qu_common)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  flush_i      in   1   drop all held/incoming instructions (branch redirect)
//  valid_i      in   1   fetch presents instr_i/pc_i
//  ready_o      out  1   decode can accept; registered
//  instr_i      in   32  instruction word
//  pc_i         in   12  PC of instr_i
//  valid_o      out  1   decoded bundle valid
//  ready_i      in   1   execute accepts bundle
//  pc_o         out  12  PC of decoded instruction
//  opcode_o     out  7   instr[6:0]
//  rd_o         out  5   dest reg; 0 for S/B/FENCE.I/ECALL/EBREAK
//  rs1_o        out  5   src reg 1; 0 for U/J
//  rs2_o        out  5   src reg 2; 0 unless R/S/B
//  funct3_o     out  3   instr[14:12]; 0 for U/J
//  funct7_o     out  7   instr[31:25] for R and shift-imm; else 0
//  imm_o        out  32  sign-extended immediate (U: imm[31:12]<<12); CSR: zero-ext csr addr
//  iclass_o     out  4   0 R,1 I-ALU,2 LOAD,3 S,4 B,5 JAL,6 JALR,7 LUI,8 AUIPC,9 SYS,10 CSR,11 FENCE,15 ILL
//  illegal_o    out  1   instruction illegal (iclass_o=15)
// BEHAVIOUR
//  - Reset: valid_o=0, ready_o=1, all data outputs 0, skid empty; state EMPTY.
//  - Decode combinational from instr_i; result registered. Latency 1 cycle accept->valid_o.
//  - Accept = valid_i & ready_o. Output handshake = valid_o & ready_i. ready_o = ~skid_valid.
//  - States: EMPTY (no out), FULL (out only), SKID (out+skid).
//    EMPTY: accept -> FULL (load out).
//    FULL: accept & ready_i -> FULL (load out); accept & ~ready_i -> SKID (load skid);
//          ~accept & ready_i -> EMPTY.
//    SKID: ready_i -> FULL (skid->out); else hold. No accept possible (ready_o=0).
//  - valid_o/data stable while valid_o & ~ready_i (no change until handshake).
//  - flush_i: next cycle -> EMPTY, valid_o=0, ready_o=1; input presented during flush dropped;
//    flush overrides simultaneous accept and handshake. Data outputs not cleared by flush.
//  - Immediates: I {20{i[31]},i[31:20]}; S {20{i[31]},i[31:25],i[11:7]};
//    B {19{i[31]},i[31],i[7],i[30:25],i[11:8],0}; J {11{i[31]},i[31],i[19:12],i[20],i[30:21],0};
//    U {i[31:12],12'b0}. SLLI/SRLI/SRAI imm_o = zero-ext shamt i[24:20].
//  - LOAD opcode 7'b0000011 decoded in addition to qu_common opcodes.
//  - Illegal: unknown opcode; i[1:0]!=2'b11; R funct7 not 0/0x20, or 0x20 with funct3 not 000/101;
//    shift-imm funct7 not 0 (SLLI/SRLI) or 0/0x20 (SRxI); LOAD funct3 011/110/111; STORE funct3>010;
//    BRANCH funct3 010/011; JALR funct3!=0; SYS funct3=000 with imm not 0/1 or rs1/rd!=0;
//    SYSTEM funct3=100; FENCE funct3>001. Illegal still flows with rd_o/rs*_o=0, imm_o=0.
//  - All-zero word 0x00000000 illegal.
// TESTING
//  - 0x00500093 (addi x1,x0,5) -> iclass 1, rd 1, rs1 0, imm 0x00000005, 1 cycle later.
//  - 0xFE208EE3 (beq x1,x2,-4) -> iclass 4, rs1 1, rs2 2, rd 0, imm 0xFFFFFFFC.
//  - 0x123452B7 lui x5 then 0x008000EF jal x1,+8 -> imm 0x12345000 / 0x00000008, iclass 7/5.
//  - 0x00000000 and 0x02000033 (MUL) -> illegal_o=1, iclass 15.
//  - Back-to-back valid_i, ready_i low 3 cycles: SKID entered, ready_o=0, no loss/dup, order kept.
//  - flush_i in SKID with valid_i=1 -> valid_o=0, ready_o=1 next cycle; rst_n low mid-stream -> reset values.

Source files
------------

// File: rtl/qu_instr_decode.sv
// Qu pipeline decode stage: RV32I field split, class and immediate generation,
// registered output behind a 2-entry skid buffer with a registered ready.
package qu_instr_decode_pkg;
  localparam int unsigned QU_INSTR_WIDTH = 32;
  localparam int unsigned QU_PC_WIDTH    = 12;
  localparam int unsigned OPC_W          = 7;
  localparam int unsigned REG_W          = 5;
  localparam int unsigned F3_W           = 3;
  localparam int unsigned F7_W           = 7;
  localparam int unsigned CLS_W          = 4;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_REG    = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;

  localparam logic [CLS_W-1:0] CLS_R     = 4'd0;
  localparam logic [CLS_W-1:0] CLS_IALU  = 4'd1;
  localparam logic [CLS_W-1:0] CLS_LOAD  = 4'd2;
  localparam logic [CLS_W-1:0] CLS_S     = 4'd3;
  localparam logic [CLS_W-1:0] CLS_B     = 4'd4;
  localparam logic [CLS_W-1:0] CLS_JAL   = 4'd5;
  localparam logic [CLS_W-1:0] CLS_JALR  = 4'd6;
  localparam logic [CLS_W-1:0] CLS_LUI   = 4'd7;
  localparam logic [CLS_W-1:0] CLS_AUIPC = 4'd8;
  localparam logic [CLS_W-1:0] CLS_SYS   = 4'd9;
  localparam logic [CLS_W-1:0] CLS_CSR   = 4'd10;
  localparam logic [CLS_W-1:0] CLS_FENCE = 4'd11;
  localparam logic [CLS_W-1:0] CLS_ILL   = 4'd15;

  typedef struct packed {
    logic [QU_PC_WIDTH-1:0]    pc;
    logic [OPC_W-1:0]          opcode;
    logic [REG_W-1:0]          rd;
    logic [REG_W-1:0]          rs1;
    logic [REG_W-1:0]          rs2;
    logic [F3_W-1:0]           funct3;
    logic [F7_W-1:0]           funct7;
    logic [QU_INSTR_WIDTH-1:0] imm;
    logic [CLS_W-1:0]          iclass;
    logic                      illegal;
  } dec_bundle_t;
endpackage

module qu_instr_decode
  import qu_instr_decode_pkg::*;
#(
  parameter int unsigned QU_INSTR_WIDTH = qu_instr_decode_pkg::QU_INSTR_WIDTH,
  parameter int unsigned QU_PC_WIDTH    = qu_instr_decode_pkg::QU_PC_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [QU_INSTR_WIDTH-1:0] instr_i,
  input  logic [QU_PC_WIDTH-1:0]    pc_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [QU_PC_WIDTH-1:0]    pc_o,
  output logic [6:0]                opcode_o,
  output logic [4:0]                rd_o,
  output logic [4:0]                rs1_o,
  output logic [4:0]                rs2_o,
  output logic [2:0]                funct3_o,
  output logic [6:0]                funct7_o,
  output logic [31:0]               imm_o,
  output logic [3:0]                iclass_o,
  output logic                      illegal_o
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_e;

  state_e      state_q;
  dec_bundle_t out_q;
  dec_bundle_t skid_q;
  dec_bundle_t dec;
  logic        valid_q;
  logic        ready_q;

  logic [OPC_W-1:0] op;
  logic [REG_W-1:0] rd_f, rs1_f, rs2_f;
  logic [F3_W-1:0]  f3;
  logic [F7_W-1:0]  f7;
  logic [31:0]      imm_i, imm_s, imm_b, imm_j, imm_u;
  logic             ill;

  assign op    = instr_i[6:0];
  assign rd_f  = instr_i[11:7];
  assign f3    = instr_i[14:12];
  assign rs1_f = instr_i[19:15];
  assign rs2_f = instr_i[24:20];
  assign f7    = instr_i[31:25];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};

  // Combinational decode of the incoming word
  always_comb begin
    dec        = '0;
    ill        = 1'b0;
    dec.pc     = pc_i;
    dec.opcode = op;
    case (op)
      OP_REG: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          dec.rd = rd_f; dec.rs1 = rs1_f; dec.rs2 = rs2_f;
          dec.funct3 = f3; dec.funct7 = f7; dec.iclass = CLS_R;
        end else ill = 1'b1;
      end
      OP_IMM: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.funct3 = f3; dec.iclass = CLS_IALU;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shift-immediate: funct7 carries the arithmetic flag, imm is the shamt
          dec.funct7 = f7;
          dec.imm    = {27'b0, instr_i[24:20]};
          if (!(f7 == 7'h00 || (f3 == 3'b101 && f7 == 7'h20))) ill = 1'b1;
        end else dec.imm = imm_i;
      end
      OP_LOAD: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.funct3 = f3; dec.imm = imm_i; dec.iclass = CLS_LOAD;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      end
      OP_STORE: begin
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.funct3 = f3; dec.imm = imm_s; dec.iclass = CLS_S;
        if (f3 > 3'b010) ill = 1'b1;
      end
      OP_BRANCH: begin
        dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.funct3 = f3; dec.imm = imm_b; dec.iclass = CLS_B;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      OP_JAL: begin
        dec.rd = rd_f; dec.imm = imm_j; dec.iclass = CLS_JAL;
      end
      OP_JALR: begin
        dec.rd = rd_f; dec.rs1 = rs1_f; dec.funct3 = f3; dec.imm = imm_i; dec.iclass = CLS_JALR;
        if (f3 != 3'b000) ill = 1'b1;
      end
      OP_LUI: begin
        dec.rd = rd_f; dec.imm = imm_u; dec.iclass = CLS_LUI;
      end
      OP_AUIPC: begin
        dec.rd = rd_f; dec.imm = imm_u; dec.iclass = CLS_AUIPC;
      end
      OP_SYSTEM: begin
        if (f3 == 3'b000) begin
          dec.imm = imm_i; dec.iclass = CLS_SYS;
          if (!((instr_i[31:20] == 12'h000 || instr_i[31:20] == 12'h001) &&
                rs1_f == 5'd0 && rd_f == 5'd0)) ill = 1'b1;
        end else if (f3 == 3'b100) begin
          ill = 1'b1;
        end else begin
          dec.rd = rd_f; dec.rs1 = rs1_f; dec.funct3 = f3;
          dec.imm = {20'b0, instr_i[31:20]}; dec.iclass = CLS_CSR;
        end
      end
      OP_FENCE: begin
        dec.rs1 = rs1_f; dec.funct3 = f3; dec.imm = imm_i; dec.iclass = CLS_FENCE;
        if (f3 == 3'b000) dec.rd = rd_f;
        else if (f3 != 3'b001) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) ill = 1'b1;
    if (ill) begin
      dec.rd      = '0;
      dec.rs1     = '0;
      dec.rs2     = '0;
      dec.funct3  = f3;
      dec.funct7  = '0;
      dec.imm     = '0;
      dec.iclass  = CLS_ILL;
      dec.illegal = 1'b1;
    end
  end

  // Output/skid pipeline control; ready_o tracks "skid entry free"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (flush_i) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (valid_i && ready_q) begin
            out_q   <= dec;
            valid_q <= 1'b1;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (valid_i && ready_q) begin
            if (ready_i) out_q <= dec;
            else begin
              skid_q  <= dec;
              ready_q <= 1'b0;
              state_q <= ST_SKID;
            end
          end else if (ready_i) begin
            valid_q <= 1'b0;
            state_q <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (ready_i) begin
            out_q   <= skid_q;
            ready_q <= 1'b1;
            state_q <= ST_FULL;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign pc_o      = out_q.pc;
  assign opcode_o  = out_q.opcode;
  assign rd_o      = out_q.rd;
  assign rs1_o     = out_q.rs1;
  assign rs2_o     = out_q.rs2;
  assign funct3_o  = out_q.funct3;
  assign funct7_o  = out_q.funct7;
  assign imm_o     = out_q.imm;
  assign iclass_o  = out_q.iclass;
  assign illegal_o = out_q.illegal;

endmodule

// File: tb/tb_qu_instr_decode.sv
// Directed bench for qu_instr_decode: decode vectors, skid back-pressure, flush and reset.
module tb_qu_instr_decode;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] instr_i;
  logic [11:0] pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [11:0] pc_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] imm_o;
  logic [3:0]  iclass_o;
  logic        illegal_o;

  int n_vec = 0;
  int n_err = 0;

  qu_instr_decode dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o),
    .opcode_o(opcode_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .imm_o(imm_o), .iclass_o(iclass_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with ready_i high, then check the registered bundle
  task automatic send_check(input string tag, input logic [31:0] ins, input logic [11:0] pc,
                            input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm, input logic ill);
    chk({tag, "_rdy"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    instr_i = ins;
    pc_i    = pc;
    tick();
    valid_i = 1'b0;
    chk({tag, "_vld"}, 32'(valid_o), 32'd1);
    chk({tag, "_pc"}, 32'(pc_o), 32'(pc));
    chk({tag, "_op"}, 32'(opcode_o), 32'(ins[6:0]));
    chk({tag, "_cls"}, 32'(iclass_o), 32'(cls));
    chk({tag, "_rd"}, 32'(rd_o), 32'(rd));
    chk({tag, "_rs1"}, 32'(rs1_o), 32'(rs1));
    chk({tag, "_rs2"}, 32'(rs2_o), 32'(rs2));
    chk({tag, "_f3"}, 32'(funct3_o), 32'(f3));
    chk({tag, "_f7"}, 32'(funct7_o), 32'(f7));
    chk({tag, "_imm"}, imm_o, imm);
    chk({tag, "_ill"}, 32'(illegal_o), 32'(ill));
  endtask

  initial begin
    rst_n   = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    instr_i = '0;
    pc_i    = '0;
    tick();
    tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_pc", 32'(pc_o), 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    chk("rst_cls", 32'(iclass_o), 32'd0);
    chk("rst_ill", 32'(illegal_o), 32'd0);
    rst_n   = 1'b1;
    ready_i = 1'b1;
    tick();

    //                 tag      instr         pc      cls   rd    rs1   rs2   f3    f7     imm           ill
    send_check("addi", 32'h00500093, 12'h004, 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000005, 1'b0);
    send_check("beq",  32'hFE208EE3, 12'h008, 4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0);
    send_check("lui",  32'h123452B7, 12'h00C, 4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b0);
    send_check("jal",  32'h008000EF, 12'h010, 4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 1'b0);
    send_check("zero", 32'h00000000, 12'h014, 4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1);
    send_check("mul",  32'h02000033, 12'h018, 4'd15, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1);
    send_check("srai", 32'h4030D093, 12'h01C, 4'd1, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'h00000003, 1'b0);
    send_check("lw",   32'h0040A183, 12'h020, 4'd2, 5'd3, 5'd1, 5'd0, 3'd2, 7'h00, 32'h00000004, 1'b0);
    send_check("csrw", 32'h305110F3, 12'h024, 4'd10, 5'd1, 5'd2, 5'd0, 3'd1, 7'h00, 32'h00000305, 1'b0);
    send_check("ecal", 32'h00000073, 12'h028, 4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0);

    // Drain to EMPTY
    tick();
    chk("drain_valid", 32'(valid_o), 32'd0);

    // Back-pressure: A, B, C back to back with ready_i low for 3 cycles
    ready_i = 1'b0;
    valid_i = 1'b1; instr_i = 32'h00100093; pc_i = 12'h040;
    tick();
    chk("skA_valid", 32'(valid_o), 32'd1);
    chk("skA_pc", 32'(pc_o), 32'h040);
    chk("skA_ready", 32'(ready_o), 32'd1);
    instr_i = 32'h00200113; pc_i = 12'h044;
    tick();
    chk("skB_ready", 32'(ready_o), 32'd0);
    chk("skB_pc_hold", 32'(pc_o), 32'h040);
    chk("skB_rd_hold", 32'(rd_o), 32'd1);
    instr_i = 32'h00300193; pc_i = 12'h048;
    tick();
    chk("skC_ready", 32'(ready_o), 32'd0);
    chk("skC_valid", 32'(valid_o), 32'd1);
    chk("skC_pc_hold", 32'(pc_o), 32'h040);
    ready_i = 1'b1;
    tick();
    chk("out_B_pc", 32'(pc_o), 32'h044);
    chk("out_B_rd", 32'(rd_o), 32'd2);
    chk("out_B_ready", 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0;
    chk("out_C_pc", 32'(pc_o), 32'h048);
    chk("out_C_rd", 32'(rd_o), 32'd3);
    chk("out_C_imm", imm_o, 32'd3);
    tick();
    chk("post_skid_empty", 32'(valid_o), 32'd0);

    // Flush while in SKID with a new instruction presented
    ready_i = 1'b0;
    valid_i = 1'b1; instr_i = 32'h00100093; pc_i = 12'h050;
    tick();
    instr_i = 32'h00200113; pc_i = 12'h054;
    tick();
    chk("fl_skid_ready", 32'(ready_o), 32'd0);
    flush_i = 1'b1;
    ready_i = 1'b1;
    instr_i = 32'h00300193; pc_i = 12'h058;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("fl_valid", 32'(valid_o), 32'd0);
    chk("fl_ready", 32'(ready_o), 32'd1);
    chk("fl_pc_kept", 32'(pc_o), 32'h050);
    tick();
    chk("fl_dropped", 32'(valid_o), 32'd0);
    send_check("post_fl", 32'h00500093, 12'h05C, 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000005, 1'b0);

    // Asynchronous reset mid-stream
    ready_i = 1'b0;
    valid_i = 1'b1; instr_i = 32'h123452B7; pc_i = 12'h060;
    tick();
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd1);
    chk("mid_rst_pc", 32'(pc_o), 32'd0);
    chk("mid_rst_imm", imm_o, 32'd0);
    chk("mid_rst_rd", 32'(rd_o), 32'd0);
    valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_rst_valid", 32'(valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
